// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit; define MDU_MUL_ITER_EN for a shift-add multiply, otherwise the multiply is single-cycle
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         op,
  input  logic               start,
  input  logic               annul,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy,
  output logic               stall_req
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nxt;
  logic [WIDTH-1:0] rem, quo, dvs, a_mag, b_mag, rem_f, quo_f;
  logic [CW-1:0] cnt;
  logic [1:0] op_q;
  logic neg_q, neg_r, a_neg, b_neg, accept, dz, quick, ge;
  logic [WIDTH:0] sh, diff;
  logic [2*WIDTH-1:0] res_q, res_calc, mul_mag;
`ifdef MDU_MUL_ITER_EN
  logic [WIDTH:0] sum;
  assign sum = {1'b0, rem} + (quo[0] ? {1'b0, dvs} : '0);
  assign quick = op[1] & dz;
`else
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{a_neg}}, src1} * {{WIDTH{b_neg}}, src2};
  assign quick = ~op[1] | dz;
`endif
  assign accept = state == IDLE & start & ~annul;
  assign a_neg = ~op[0] & src1[WIDTH-1];
  assign b_neg = ~op[0] & src2[WIDTH-1];
  assign a_mag = a_neg ? -src1 : src1;
  assign b_mag = b_neg ? -src2 : src2;
  assign dz = src2 == '0;
  assign sh = {rem, quo[WIDTH-1]};
  assign diff = sh - {1'b0, dvs};
  assign ge = ~diff[WIDTH];
  assign quo_f = neg_q ? -quo : quo;
  assign rem_f = neg_r ? -rem : rem;
  assign mul_mag = {rem, quo};
  assign res_calc = op_q[1] ? {rem_f, quo_f} : (neg_q ? -mul_mag : mul_mag);
  assign busy = state == CALC;
  assign stall_req = accept | busy;
  assign ready = state == DONE & ~annul & ~rst;
  assign result = ready ? res_calc : res_q;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  // next-state: annul aborts, counter ends the iteration
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = quick ? DONE : CALC;
      CALC: state_nxt = annul ? IDLE : (cnt == CW'(WIDTH - 1) ? DONE : CALC);
      default: state_nxt = IDLE;
    endcase
  end
  // operand load, one iteration step per CALC cycle, result commit on ready
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      op_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res_q <= '0;
    end else if (accept) begin
      cnt <= '0;
      op_q <= op;
      if (op[1] & dz) begin
        rem <= src1;
        quo <= '1;
        dvs <= src2;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else if (op[1]) begin
        rem <= '0;
        quo <= a_mag;
        dvs <= b_mag;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end else begin
`ifdef MDU_MUL_ITER_EN
        rem <= '0;
        quo <= b_mag;
        dvs <= a_mag;
        neg_q <= a_neg ^ b_neg;
        neg_r <= 1'b0;
`else
        {rem, quo} <= prod;
        dvs <= src2;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
`endif
      end
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (op_q[1]) begin
        rem <= ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ge};
      end
`ifdef MDU_MUL_ITER_EN
      else begin
        rem <= sum[WIDTH:1];
        quo <= {sum[0], quo[WIDTH-1:1]};
      end
`endif
    end else if (ready) res_q <= res_calc;
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: vector table, corner sequences and random ops against an arithmetic model
module tb_mdu_iter;
`ifdef MDU_MUL_ITER_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 1;
`endif
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, annul = 0;
  logic [1:0] op = 0;
  logic [31:0] src1 = 0, src2 = 0;
  logic [63:0] result, last_res;
  logic ready, busy, stall_req;
  int n_chk = 0, n_fail = 0;
  vec_t vt[12];
  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op(op), .start(start), .annul(annul),
    .src1(src1), .src2(src2), .result(result), .ready(ready),
    .busy(busy), .stall_req(stall_req)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'd0) return 64'(sa * sb);
    if (o == 2'd1) return {32'd0, a} * {32'd0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (o == 2'd2) return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction
  function automatic int lat_of(input logic [1:0] o, input logic [31:0] b);
    return o[1] ? (b == 0 ? 1 : 33) : MUL_LAT;
  endfunction
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int lat, stalls, busys;
    logic [63:0] res;
    op = o; src1 = a; src2 = b; start = 1;
    #1 chk("stall_t", 64'(stall_req), 64'd1);
    lat = 0; stalls = 0; busys = 0;
    do begin
      @(negedge clk);
      start = 0;
      #1 lat++;
      stalls += int'(stall_req);
      busys += int'(busy);
    end while (!ready && lat < 100);
    res = result;
    chk("result", res, exp);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("stall_cycles", 64'(stalls), 64'(exp_lat - 1));
    chk("busy_cycles", 64'(busys), 64'(exp_lat - 1));
    @(negedge clk);
    #1 chk("ready_pulse", 64'(ready), 64'd0);
    chk("result_hold", result, exp);
    last_res = exp;
  endtask
  initial begin
    bit seen;
    logic [1:0] o;
    logic [31:0] a, b;
    vt[0]  = '{2'd3, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
    vt[1]  = '{2'd2, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33};
    vt[2]  = '{2'd2, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33};
    vt[3]  = '{2'd2, 32'd5,          32'd0,          64'h00000005_FFFFFFFF, 1};
    vt[4]  = '{2'd0, 32'hFFFFFFFD,   32'd5,          64'hFFFFFFFF_FFFFFFF1, MUL_LAT};
    vt[5]  = '{2'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001, MUL_LAT};
    vt[6]  = '{2'd0, 32'h80000000,   32'h80000000,   64'h40000000_00000000, MUL_LAT};
    vt[7]  = '{2'd2, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33};
    vt[8]  = '{2'd3, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33};
    vt[9]  = '{2'd3, 32'd3,          32'd0,          64'h00000003_FFFFFFFF, 1};
    vt[10] = '{2'd0, 32'd7,          32'hFFFFFFFF,   64'hFFFFFFFF_FFFFFFF9, MUL_LAT};
    vt[11] = '{2'd1, 32'd0,          32'd12345,      64'h0, MUL_LAT};
    repeat (2) @(negedge clk);
    rst = 0;
    #1 chk("rst_result", result, 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    last_res = 0;
    for (int i = 0; i < 12; i++) run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].lat);
    // annul mid-division at t+10, restart at t+11
    op = 2'd3; src1 = 32'd1000; src2 = 32'd3; start = 1;
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 0;
      if (k == 10) annul = 1;
      #1 seen |= ready;
    end
    @(negedge clk);
    annul = 0;
    #1 chk("annul_idle", 64'(busy), 64'd0);
    chk("annul_no_ready", 64'(seen | ready), 64'd0);
    chk("annul_result", result, last_res);
    run_op(2'd3, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    // annul in DONE suppresses the ready pulse and the result update
    op = 2'd2; src1 = 32'd5; src2 = 32'd0; start = 1;
    @(negedge clk);
    start = 0; annul = 1;
    #1 chk("annul_done_ready", 64'(ready), 64'd0);
    chk("annul_done_result", result, last_res);
    @(negedge clk);
    annul = 0;
    #1 chk("annul_done_idle", 64'(ready | busy), 64'd0);
    chk("annul_done_hold", result, last_res);
    // start and annul together: nothing starts
    op = 2'd3; src1 = 32'd9; src2 = 32'd2; start = 1; annul = 1;
    #1 chk("start_annul_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    start = 0; annul = 0;
    seen = 0;
    repeat (3) begin
      #1 seen |= ready | busy;
      @(negedge clk);
    end
    chk("start_annul_nothing", 64'(seen), 64'd0);
    // reset at t+5 of a division
    op = 2'd2; src1 = 32'h01234567; src2 = 32'd3; start = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 0;
      if (k == 5) rst = 1;
    end
    @(negedge clk);
    rst = 0;
    #1 chk("midrst_result", result, 64'd0);
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_stall", 64'(stall_req), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1 seen |= ready;
    end
    chk("midrst_no_ready", 64'(seen), 64'd0);
    last_res = 0;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 8 == 3) b = 0;
      if (i % 4 == 1) b = 32'($urandom_range(1, 20));
      if (i % 9 == 2) a = 32'h80000000;
      run_op(o, a, b, model(o, a, b), lat_of(o, b));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, minimum 8.
REQ-002 SHALL have port clk  input  1: clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL have port op  input  2: operation, 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-005 SHALL have port start  input  1: request a new operation.
REQ-006 SHALL have port annul  input  1: abort the operation in flight.
REQ-007 SHALL have port src1  input  WIDTH: multiplicand or dividend.
REQ-008 SHALL have port src2  input  WIDTH: multiplier or divisor.
REQ-009 SHALL have port result  output  2*WIDTH: mul = full product; div = {remainder, quotient} (hi, lo).
REQ-010 SHALL have port ready  output  1: result valid, single-cycle pulse.
REQ-011 SHALL have port busy  output  1: high in state CALC.
REQ-012 SHALL have port stall_req  output  1: combinational pipeline-hold request.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 SHALL accept start only in IDLE with annul low, latching op, src1 and src2 on that edge (cycle t); start in CALC/DONE is ignored.
REQ-015 SHALL, for div/divu with src2 != 0, go IDLE->CALC, run restoring division one quotient bit per cycle for exactly WIDTH cycles, then go to DONE; ready is high in cycle t+WIDTH+1.
REQ-016 SHALL, for div/divu with src2 == 0, go IDLE->DONE with result = {src1, all ones}; ready is high in cycle t+1.
REQ-017 SHALL compute signed division on magnitudes, negating the quotient when the operand signs differ and giving the remainder the sign of the dividend.
REQ-018 SHALL return quotient = most-negative value and remainder = 0 for most-negative / -1 signed, with no exception flagged.
REQ-019 SHALL compute mult as the 2*WIDTH-bit two's-complement product and multu as the unsigned product.
REQ-020 SHALL assert ready for exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL hold result stable from DONE until the next accepted start.
REQ-022 SHALL, on annul in CALC or DONE, return to IDLE on the next edge with no ready pulse and result unchanged from its previous value.
REQ-023 SHALL give annul priority when start and annul are high in the same IDLE cycle: no operation starts.
REQ-024 SHALL drive stall_req = (IDLE & start & ~annul) | CALC, so stall_req is low in the ready cycle.
REQ-025 SHALL drive busy high only in CALC.

Reset
REQ-026 SHALL, on rst, enter IDLE and clear result to 0, ready to 0, busy to 0 and all internal iteration counters and shift registers.
REQ-027 SHALL, on rst mid-operation, discard the operation with no ready pulse; rst overrides start and annul.

Configuration
REQ-028 SHALL use macro MDU_MUL_ITER_EN: when defined, mult/multu run a shift-add multiply in CALC for WIDTH cycles (ready at t+WIDTH+1, signed handled via magnitudes and sign fix-up); when undefined, mult/multu compute in one cycle, going IDLE->DONE with ready at t+1.

Verification
REQ-029 SHALL cover WIDTH=32, divu src1=100, src2=7 -> ready at t+33, result hi=0x00000002, lo=0x0000000E.
REQ-030 SHALL cover div src1=0xFFFFFFF9 (-7), src2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 SHALL cover div src1=5, src2=0 -> ready at t+1, hi=0x00000005, lo=0xFFFFFFFF, stall_req high only in cycle t.
REQ-032 SHALL cover mult src1=0xFFFFFFFD, src2=5 -> result 0xFFFFFFFF_FFFFFFF1, ready at t+33 with MDU_MUL_ITER_EN and at t+1 without.
REQ-033 SHALL cover divu started then annul at t+10 -> no ready, IDLE at t+11, a new start at t+11 is accepted and completes correctly.
REQ-034 SHALL cover rst asserted at t+5 of a div -> all outputs 0 next cycle, no ready pulse.
